// File: rtl/uart_rx_arbiter_if.sv
// UART RX arbiter bus: FIFO read port, two requester grant channels
// and flush/status signals.
interface uart_rx_arbiter_if;
    logic [7:0] fifo_data;
    logic [7:0] fifo_count;
    logic       fifo_next;
    logic       req0;
    logic       req1;
    logic       ack0;
    logic       ack1;
    logic [7:0] dout0;
    logic [7:0] dout1;
    logic       flush;
    logic       flush_done;
    logic       irq;
    logic       busy;

    modport master (
        input  fifo_data, fifo_count, req0, req1, flush,
        output fifo_next, ack0, ack1, dout0, dout1,
        output flush_done, irq, busy
    );

    modport slave (
        output fifo_data, fifo_count, req0, req1, flush,
        input  fifo_next, ack0, ack1, dout0, dout1,
        input  flush_done, irq, busy
    );
endinterface

// File: rtl/uart_rx_arbiter.sv
// Round-robin read-side arbiter for the UART RX FIFO with flush
// sequencer and fill-level interrupt.
module uart_rx_arbiter #(
    parameter int THRESH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    uart_rx_arbiter_if.master bus
);
    typedef enum logic [1:0] {
        IDLE,
        POP,
        FLUSH,
        FLUSH_POP
    } state_t;

    state_t     state, state_d;
    logic       ptr, ptr_d;
    logic       next_q, next_d;
    logic       ack0_q, ack0_d;
    logic       ack1_q, ack1_d;
    logic [7:0] dout0_q, dout0_d;
    logic [7:0] dout1_q, dout1_d;
    logic       done_q, done_d;
    logic       irq_q;
    logic       have;
    logic       pick1;

    assign have  = bus.fifo_count != 8'd0;
    // ptr high means requester 1 wins a tie
    assign pick1 = bus.req1 && (!bus.req0 || ptr);

    always_comb begin
        state_d = state;
        ptr_d   = ptr;
        next_d  = 1'b0;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        dout0_d = dout0_q;
        dout1_d = dout1_q;
        done_d  = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.flush) begin
                    state_d = FLUSH;
                end else if (have && (bus.req0 || bus.req1)) begin
                    next_d  = 1'b1;
                    ptr_d   = !pick1;
                    state_d = POP;
                    if (pick1) begin
                        ack1_d  = 1'b1;
                        dout1_d = bus.fifo_data;
                    end else begin
                        ack0_d  = 1'b1;
                        dout0_d = bus.fifo_data;
                    end
                end
            end
            POP: state_d = IDLE;
            FLUSH: begin
                if (!have) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    next_d  = 1'b1;
                    state_d = FLUSH_POP;
                end
            end
            FLUSH_POP: state_d = FLUSH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ptr     <= 1'b0;
            next_q  <= 1'b0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            dout0_q <= 8'h00;
            dout1_q <= 8'h00;
            done_q  <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            state   <= state_d;
            ptr     <= ptr_d;
            next_q  <= next_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            dout0_q <= dout0_d;
            dout1_q <= dout1_d;
            done_q  <= done_d;
            irq_q   <= bus.fifo_count >= 8'(THRESH);
        end
    end

    assign bus.fifo_next  = next_q;
    assign bus.ack0       = ack0_q;
    assign bus.ack1       = ack1_q;
    assign bus.dout0      = dout0_q;
    assign bus.dout1      = dout1_q;
    assign bus.flush_done = done_q;
    assign bus.irq        = irq_q;
    assign bus.busy       = state != IDLE;
endmodule

// File: tb/tb_uart_rx_arbiter.sv
// Scoreboard bench for uart_rx_arbiter: behavioural FIFO, random
// requester/flush traffic, transaction-level round-robin model.
module tb_uart_rx_arbiter;
    localparam int THRESH = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_rx_arbiter_if bus ();

    uart_rx_arbiter #(.THRESH(THRESH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int         kind;
        logic [7:0] data;
    } exp_t;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] fq[$];
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic [7:0] cnt_prev = 8'h00;

    exp_t       eq[$];
    logic [7:0] mq[$];
    int         mptr = 0;

    logic [7:0] hold0 = 8'h00;
    logic [7:0] hold1 = 8'h00;
    exp_t       me;
    int         mk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Behavioural FIFO: pops on a high fifo_next cycle, accepts writes
    always @(posedge clk) begin
        cnt_prev <= bus.fifo_count;
        if (bus.fifo_next && fq.size() > 0) fq.delete(0);
        if (wr_en) fq.push_back(wr_data);
        bus.fifo_count <= 8'(fq.size());
        bus.fifo_data  <= (fq.size() > 0) ? fq[0] : 8'h00;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            hold0 = 8'h00;
            hold1 = 8'h00;
        end else begin
            if (bus.ack0 || bus.ack1 || bus.flush_done) begin
                if (eq.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL spurious_event: ack0=%b ack1=%b done=%b expected none at %0t",
                             bus.ack0, bus.ack1, bus.flush_done, $time);
                end else begin
                    me = eq.pop_front();
                    mk = bus.ack0 ? 0 : (bus.ack1 ? 1 : 2);
                    check("event_kind", 32'(mk), 32'(me.kind));
                    if (me.kind == 0) hold0 = me.data;
                    if (me.kind == 1) hold1 = me.data;
                    if (me.kind == 2) begin
                        check("flush_empty", 32'(fq.size()), 32'd0);
                        check("idle_after_flush", 32'(bus.busy), 32'd0);
                    end
                end
            end
            if (bus.ack0 || bus.ack1) begin
                check("ack_with_pop", 32'(bus.fifo_next), 32'd1);
                check("single_ack", 32'(bus.ack0 & bus.ack1), 32'd0);
            end
            check("dout0", 32'(bus.dout0), 32'(hold0));
            check("dout1", 32'(bus.dout1), 32'(hold1));
            check("irq", 32'(bus.irq), 32'(cnt_prev >= 8'(THRESH)));
        end
    end

    // Round-robin outcome of serving the given per-requester byte quotas
    task automatic predict(input int q0, input int q1);
        int   w;
        exp_t e;
        while (q0 > 0 || q1 > 0) begin
            if (q0 > 0 && q1 > 0) w = mptr;
            else w = (q0 > 0) ? 0 : 1;
            e.kind = w;
            e.data = mq.pop_front();
            eq.push_back(e);
            mptr = 1 - w;
            if (w == 0) q0--;
            else q1--;
        end
    endtask

    task automatic drive(input int q0i, input int q1i);
        int q0;
        int q1;
        int n;
        q0 = q0i;
        q1 = q1i;
        n = 0;
        bus.req0 = q0 > 0;
        bus.req1 = q1 > 0;
        while ((q0 > 0 || q1 > 0) && n < 400) begin
            @(posedge clk);
            #1;
            if (bus.ack0) q0--;
            if (bus.ack1) q1--;
            bus.req0 = q0 > 0;
            bus.req1 = q1 > 0;
            wr_en = ($urandom_range(0, 3) == 0);
            if (wr_en) begin
                wr_data = 8'($urandom);
                mq.push_back(wr_data);
            end
            n++;
        end
        if (q0 > 0 || q1 > 0) check("grant_timeout", 32'(q0 + q1), 32'd0);
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.busy && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (bus.busy) check("idle_timeout", 32'(bus.busy), 32'd0);
    endtask

    task automatic fill(input int n);
        for (int i = 0; i < n; i++) begin
            wr_en = 1'b1;
            wr_data = 8'($urandom);
            mq.push_back(wr_data);
            @(posedge clk);
            #1;
        end
        wr_en = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_flush(input logic hold_req0);
        exp_t e;
        int   n;
        wait_idle();
        mq.delete();
        e.kind = 2;
        e.data = 8'h00;
        eq.push_back(e);
        bus.flush = 1'b1;
        bus.req0 = hold_req0;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        n = 0;
        while (eq.size() > 0 && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (eq.size() > 0) begin
            check("flush_timeout", 32'(eq.size()), 32'd0);
            eq.delete();
        end
    endtask

    initial begin
        int         mode;
        int         t;
        int         a;
        int         n;
        logic [7:0] b;
        exp_t       e;

        bus.req0  = 1'b0;
        bus.req1  = 1'b0;
        bus.flush = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack0", 32'(bus.ack0), 32'd0);
        check("rst_ack1", 32'(bus.ack1), 32'd0);
        check("rst_next", 32'(bus.fifo_next), 32'd0);
        check("rst_done", 32'(bus.flush_done), 32'd0);
        check("rst_irq", 32'(bus.irq), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_dout0", 32'(bus.dout0), 32'd0);
        check("rst_dout1", 32'(bus.dout1), 32'd0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int it = 0; it < 40; it++) begin
            fill($urandom_range(0, 6));
            mode = $urandom_range(0, 3);
            if (mq.size() == 0) mode = 3;
            wait_idle();
            if (mode == 0) begin
                a = $urandom_range(1, mq.size());
                predict(a, 0);
                drive(a, 0);
            end else if (mode == 1) begin
                a = $urandom_range(1, mq.size());
                predict(0, a);
                drive(0, a);
            end else if (mode == 2) begin
                t = $urandom_range(1, mq.size());
                a = $urandom_range(0, t);
                predict(a, t - a);
                drive(a, t - a);
            end else begin
                do_flush(1'b1);
                repeat (4) begin
                    @(posedge clk);
                    #1;
                end
                b = 8'($urandom);
                mq.push_back(b);
                predict(1, 0);
                wr_en = 1'b1;
                wr_data = b;
                drive(1, 0);
            end
        end

        // Abort a grant with reset while its pop cycle is in flight
        do_flush(1'b0);
        fill(2);
        wait_idle();
        e.kind = 1;
        e.data = mq[0];
        eq.push_back(e);
        bus.req1 = 1'b1;
        n = 0;
        while (!bus.ack1 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("abort_ack_seen", 32'(bus.ack1), 32'd1);
        #6;
        rst_n = 1'b0;
        bus.req1 = 1'b0;
        #1;
        check("abort_ack1", 32'(bus.ack1), 32'd0);
        check("abort_next", 32'(bus.fifo_next), 32'd0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("abort_dout1", 32'(bus.dout1), 32'd0);
        check("abort_count", 32'(bus.fifo_count), 32'd2);
        mptr = 0;
        predict(1, 1);
        drive(1, 1);
        wait_idle();
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("queue_drained", 32'(eq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
